// File: rtl/rvfi_cmp_pkg.sv
// -----------------------------------------------------------------------------
// rvfi_cmp_pkg
// Shared types for the RVFI lockstep checker.
//   rvfi_cmp_rec_t : one retirement record as seen by the checker
//   CMP_*          : bit positions of each compared field in the field masks
//   cmp_state_e    : checker state (RUN compares, HALT freezes after a mismatch)
// -----------------------------------------------------------------------------
package rvfi_cmp_pkg;

    localparam int RVFI_XLEN   = 64;
    localparam int CMP_NFIELDS = 10;

    localparam int CMP_ORDER     = 0;
    localparam int CMP_INSN      = 1;
    localparam int CMP_TRAP      = 2;
    localparam int CMP_PC_RDATA  = 3;
    localparam int CMP_PC_WDATA  = 4;
    localparam int CMP_RD1_ADDR  = 5;
    localparam int CMP_RD1_WDATA = 6;
    localparam int CMP_MEM_ADDR  = 7;
    localparam int CMP_MEM_WDATA = 8;
    localparam int CMP_WMASK     = 9;

    typedef struct packed {
        logic [63:0]           order;
        logic [31:0]           insn;
        logic                  trap;
        logic [RVFI_XLEN-1:0]  pc_rdata;
        logic [RVFI_XLEN-1:0]  pc_wdata;
        logic [4:0]            rd1_addr;
        logic [RVFI_XLEN-1:0]  rd1_wdata;
        logic [RVFI_XLEN-1:0]  mem_addr;
        logic [7:0]            mem_rmask;
        logic [7:0]            mem_wmask;
        logic [RVFI_XLEN-1:0]  mem_wdata;
    } rvfi_cmp_rec_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } cmp_state_e;

endpackage

// File: rtl/rvfi_cmp_fifo.sv
// -----------------------------------------------------------------------------
// rvfi_cmp_fifo
// Synchronous FIFO for one retirement stream. Written records become visible
// at the head on the cycle after the push (no bypass).
//   clk_i, rst_ni : clock, synchronous active-low reset
//   flush_i       : empties the FIFO; wins over push/pop in the same cycle
//   push_i/data_i : write request; ignored when full unless a pop frees a slot
//   pop_i         : remove the head entry (ignored when empty)
//   data_o        : head entry, valid while empty_o is low
//   full_o/empty_o: occupancy flags
// Pointers carry one extra MSB so that full and empty differ after wrap.
// -----------------------------------------------------------------------------
module rvfi_cmp_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop on a full FIFO frees the slot the push lands in, so both proceed.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign data_o  = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && do_push) begin
            mem[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/rvfi_lockstep_checker.sv
// -----------------------------------------------------------------------------
// rvfi_lockstep_checker
// Pairs reference-model and DUT retirement records in order and compares them.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   ref_valid_i/rec_i  : reference record stream
//   dut_valid_i/rec_i  : DUT retirement stream
//   clear_i            : flush FIFOs and compare stage, clear sticky flags
//   match_count_o      : saturating count of matching pairs
//   mismatch_o         : sticky, first mismatch seen
//   mismatch_fields_o  : differing fields of the first mismatching pair
//   mismatch_order_o   : reference order of the first mismatching pair
//   overflow_o         : sticky, push into a full FIFO was dropped
//   idle_o             : both FIFOs empty and compare stage empty
// Handshake: both input streams are valid-only; a record is consumed on every
// clock edge where its valid is high. There is no ready, so a record arriving
// at a full FIFO (with no pop that cycle) is dropped and flagged as overflow.
// -----------------------------------------------------------------------------
module rvfi_lockstep_checker
    import rvfi_cmp_pkg::*;
#(
    parameter int                     XLEN     = 64,
    parameter int                     DEPTH    = 8,
    parameter logic [CMP_NFIELDS-1:0] CMP_MASK = 10'h3FF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ref_valid_i,
    input  rvfi_cmp_rec_t          ref_rec_i,
    input  logic                   dut_valid_i,
    input  rvfi_cmp_rec_t          dut_rec_i,
    input  logic                   clear_i,
    output logic [31:0]            match_count_o,
    output logic                   mismatch_o,
    output logic [CMP_NFIELDS-1:0] mismatch_fields_o,
    output logic [63:0]            mismatch_order_o,
    output logic                   overflow_o,
    output logic                   idle_o
);

    rvfi_cmp_rec_t          ref_head;
    rvfi_cmp_rec_t          dut_head;
    logic                   ref_full;
    logic                   ref_empty;
    logic                   dut_full;
    logic                   dut_empty;
    logic                   pop;

    cmp_state_e             state_q;
    logic                   cmp_valid_q;
    rvfi_cmp_rec_t          ref_q;
    rvfi_cmp_rec_t          dut_q;
    logic [31:0]            match_count_q;
    logic                   mismatch_q;
    logic [CMP_NFIELDS-1:0] mismatch_fields_q;
    logic [63:0]            mismatch_order_q;
    logic                   overflow_q;

    logic [XLEN-1:0]        lane_mask;
    logic [CMP_NFIELDS-1:0] raw_diff;
    logic [CMP_NFIELDS-1:0] diff;
    logic                   cmp_fail;
    logic                   unused_dut_rmask;

    // The DUT's read mask is carried in the record but never compared.
    assign unused_dut_rmask = ^dut_q.mem_rmask;

    rvfi_cmp_fifo #(.DEPTH(DEPTH), .T(rvfi_cmp_rec_t)) u_ref_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .push_i  (ref_valid_i),
        .data_i  (ref_rec_i),
        .pop_i   (pop),
        .data_o  (ref_head),
        .full_o  (ref_full),
        .empty_o (ref_empty)
    );

    rvfi_cmp_fifo #(.DEPTH(DEPTH), .T(rvfi_cmp_rec_t)) u_dut_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .push_i  (dut_valid_i),
        .data_i  (dut_rec_i),
        .pop_i   (pop),
        .data_o  (dut_head),
        .full_o  (dut_full),
        .empty_o (dut_empty)
    );

    // Field comparison of the pair held in the compare stage. Qualifiers come
    // from the reference record: rd1 data only matters for a real destination,
    // the address only for an actual access, and only written byte lanes count.
    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < XLEN / 8; b++) begin
            lane_mask[8*b +: 8] = {8{ref_q.mem_wmask[b]}};
        end

        raw_diff = '0;
        raw_diff[CMP_ORDER]     = (ref_q.order    != dut_q.order);
        raw_diff[CMP_INSN]      = (ref_q.insn     != dut_q.insn);
        raw_diff[CMP_TRAP]      = (ref_q.trap     != dut_q.trap);
        raw_diff[CMP_PC_RDATA]  = (ref_q.pc_rdata != dut_q.pc_rdata);
        raw_diff[CMP_PC_WDATA]  = (ref_q.pc_wdata != dut_q.pc_wdata);
        raw_diff[CMP_RD1_ADDR]  = (ref_q.rd1_addr != dut_q.rd1_addr);
        raw_diff[CMP_RD1_WDATA] = (ref_q.rd1_addr != 5'd0) &&
                                  (ref_q.rd1_wdata != dut_q.rd1_wdata);
        raw_diff[CMP_MEM_ADDR]  = (|(ref_q.mem_rmask | ref_q.mem_wmask)) &&
                                  (ref_q.mem_addr != dut_q.mem_addr);
        raw_diff[CMP_MEM_WDATA] = (((ref_q.mem_wdata ^ dut_q.mem_wdata) & lane_mask) != '0);
        raw_diff[CMP_WMASK]     = (ref_q.mem_wmask != dut_q.mem_wmask);
    end

    assign diff     = raw_diff & CMP_MASK;
    assign cmp_fail = cmp_valid_q && (diff != '0);

    // No pop while the stage holds a failing pair: the checker is about to
    // halt and every later pair must stay buffered for inspection.
    assign pop = (state_q == ST_RUN) && !cmp_fail && !ref_empty && !dut_empty && !clear_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q           <= ST_RUN;
            cmp_valid_q       <= 1'b0;
            ref_q             <= '0;
            dut_q             <= '0;
            match_count_q     <= '0;
            mismatch_q        <= 1'b0;
            mismatch_fields_q <= '0;
            mismatch_order_q  <= '0;
            overflow_q        <= 1'b0;
        end else if (clear_i) begin
            state_q           <= ST_RUN;
            cmp_valid_q       <= 1'b0;
            mismatch_q        <= 1'b0;
            mismatch_fields_q <= '0;
            mismatch_order_q  <= '0;
            overflow_q        <= 1'b0;
        end else begin
            cmp_valid_q <= pop;
            if (pop) begin
                ref_q <= ref_head;
                dut_q <= dut_head;
            end

            if (cmp_valid_q && state_q == ST_RUN) begin
                if (cmp_fail) begin
                    mismatch_q        <= 1'b1;
                    mismatch_fields_q <= diff;
                    mismatch_order_q  <= ref_q.order;
                    state_q           <= ST_HALT;
                end else if (match_count_q != 32'hFFFF_FFFF) begin
                    match_count_q <= match_count_q + 32'd1;
                end
            end

            if ((ref_valid_i && ref_full && !pop) || (dut_valid_i && dut_full && !pop)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign match_count_o     = match_count_q;
    assign mismatch_o        = mismatch_q;
    assign mismatch_fields_o = mismatch_fields_q;
    assign mismatch_order_o  = mismatch_order_q;
    assign overflow_o        = overflow_q;
    assign idle_o            = ref_empty && dut_empty && !cmp_valid_q;

endmodule

// File: tb/tb_rvfi_lockstep_checker.sv
// -----------------------------------------------------------------------------
// tb_rvfi_lockstep_checker
// Directed bench for the lockstep checker. A queue-based model of the two
// streams predicts every output on each cycle; literal checks pin the model at
// the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_rvfi_lockstep_checker;
    import rvfi_cmp_pkg::*;

    localparam int         DEPTH = 8;
    localparam logic [9:0] MASK  = 10'h3FF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          clear = 1'b0;
    logic          ref_valid = 1'b0;
    logic          dut_valid = 1'b0;
    rvfi_cmp_rec_t ref_rec = '0;
    rvfi_cmp_rec_t dut_rec = '0;

    logic [31:0] match_count;
    logic        mismatch;
    logic [9:0]  mismatch_fields;
    logic [63:0] mismatch_order;
    logic        overflow;
    logic        idle;

    rvfi_lockstep_checker #(.XLEN(64), .DEPTH(DEPTH), .CMP_MASK(MASK)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .ref_valid_i       (ref_valid),
        .ref_rec_i         (ref_rec),
        .dut_valid_i       (dut_valid),
        .dut_rec_i         (dut_rec),
        .clear_i           (clear),
        .match_count_o     (match_count),
        .mismatch_o        (mismatch),
        .mismatch_fields_o (mismatch_fields),
        .mismatch_order_o  (mismatch_order),
        .overflow_o        (overflow),
        .idle_o            (idle)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Fields differ by the comparison rules, written field by field.
    function automatic logic [9:0] model_diff(input rvfi_cmp_rec_t r, input rvfi_cmp_rec_t d);
        logic [9:0] f;
        f = '0;
        if (r.order != d.order)       f[0] = 1'b1;
        if (r.insn != d.insn)         f[1] = 1'b1;
        if (r.trap != d.trap)         f[2] = 1'b1;
        if (r.pc_rdata != d.pc_rdata) f[3] = 1'b1;
        if (r.pc_wdata != d.pc_wdata) f[4] = 1'b1;
        if (r.rd1_addr != d.rd1_addr) f[5] = 1'b1;
        if (r.rd1_addr != 5'd0 && r.rd1_wdata != d.rd1_wdata) f[6] = 1'b1;
        if ((r.mem_rmask | r.mem_wmask) != 8'd0 && r.mem_addr != d.mem_addr) f[7] = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (r.mem_wmask[b] && r.mem_wdata[8*b +: 8] != d.mem_wdata[8*b +: 8]) f[8] = 1'b1;
        end
        if (r.mem_wmask != d.mem_wmask) f[9] = 1'b1;
        return f & MASK;
    endfunction

    rvfi_cmp_rec_t m_ref_q[$];
    rvfi_cmp_rec_t m_dut_q[$];
    rvfi_cmp_rec_t m_stage_ref;
    rvfi_cmp_rec_t m_stage_dut;
    bit            m_stage_v;
    bit            m_halt;
    logic [31:0]   m_count;
    bit            m_mis;
    logic [9:0]    m_fields;
    logic [63:0]   m_order;
    bit            m_ovf;

    always @(posedge clk) begin
        bit          halting;
        logic [9:0]  f;
        if (!rst_n) begin
            m_ref_q.delete(); m_dut_q.delete();
            m_stage_v = 0; m_halt = 0; m_count = '0;
            m_mis = 0; m_fields = '0; m_order = '0; m_ovf = 0;
        end else if (clear) begin
            m_ref_q.delete(); m_dut_q.delete();
            m_stage_v = 0; m_halt = 0;
            m_mis = 0; m_fields = '0; m_order = '0; m_ovf = 0;
        end else begin
            halting = 0;
            if (m_stage_v && !m_halt) begin
                f = model_diff(m_stage_ref, m_stage_dut);
                if (f == '0) begin
                    if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
                end else begin
                    m_mis = 1; m_fields = f; m_order = m_stage_ref.order;
                    halting = 1;
                end
            end
            m_stage_v = 0;
            if (!m_halt && !halting && m_ref_q.size() > 0 && m_dut_q.size() > 0) begin
                m_stage_ref = m_ref_q.pop_front();
                m_stage_dut = m_dut_q.pop_front();
                m_stage_v = 1;
            end
            if (halting) m_halt = 1;
            if (ref_valid) begin
                if (m_ref_q.size() < DEPTH) m_ref_q.push_back(ref_rec); else m_ovf = 1;
            end
            if (dut_valid) begin
                if (m_dut_q.size() < DEPTH) m_dut_q.push_back(dut_rec); else m_ovf = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_count",  64'(match_count),     64'(m_count));
            chk("cyc_mis",    64'(mismatch),        64'(m_mis));
            chk("cyc_fields", 64'(mismatch_fields), 64'(m_fields));
            chk("cyc_order",  mismatch_order,       m_order);
            chk("cyc_ovf",    64'(overflow),        64'(m_ovf));
            chk("cyc_idle",   64'(idle),
                64'(m_ref_q.size() == 0 && m_dut_q.size() == 0 && !m_stage_v));
        end
    end

    // ---------------- driver tasks ----------------
    function automatic rvfi_cmp_rec_t mk(input int o);
        rvfi_cmp_rec_t r;
        r = '0;
        r.order     = 64'(o);
        r.insn      = 32'h13 | (32'(o) << 7);
        r.pc_rdata  = 64'h8000_0000 + 64'(o) * 4;
        r.pc_wdata  = r.pc_rdata + 4;
        r.rd1_addr  = 5'(o % 31 + 1);
        r.rd1_wdata = 64'(o) * 64'h0101_0101_0101_0101;
        return r;
    endfunction

    task automatic cyc(input bit rv, input rvfi_cmp_rec_t r, input bit dv, input rvfi_cmp_rec_t d);
        @(negedge clk);
        ref_valid = rv; ref_rec = r;
        dut_valid = dv; dut_rec = d;
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) cyc(1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        ref_valid = 0; dut_valid = 0; clear = 1;
        @(negedge clk);
        clear = 0;
    endtask

    // After any task returns, outputs reflect all posedges so far; the drive
    // made at this negedge acts on the next posedge.
    rvfi_cmp_rec_t r0;
    rvfi_cmp_rec_t d0;

    initial begin
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        chk("rst_count", 64'(match_count), 64'd0);
        chk("rst_mis",   64'(mismatch),    64'd0);
        chk("rst_ovf",   64'(overflow),    64'd0);
        chk("rst_idle",  64'(idle),        64'd1);

        // Lockstep: 5 identical pairs in the same cycles.
        for (int i = 0; i < 5; i++) cyc(1, mk(i), 1, mk(i));
        idle_cyc(2);
        chk("lock_inflight_idle", 64'(idle), 64'd0);
        idle_cyc(1);
        chk("lock_count", 64'(match_count), 64'd5);
        chk("lock_idle",  64'(idle),        64'd1);

        // DUT ahead by 6, pointers wrap.
        for (int i = 10; i < 16; i++) cyc(0, '0, 1, mk(i));
        for (int i = 10; i < 16; i++) cyc(1, mk(i), 0, '0);
        idle_cyc(3);
        chk("ahead_count", 64'(match_count), 64'd11);
        chk("ahead_ovf",   64'(overflow),    64'd0);

        // Masked-off differences still match.
        r0 = mk(20); r0.rd1_addr = 5'd0; d0 = r0; d0.rd1_wdata = ~r0.rd1_wdata;
        cyc(1, r0, 1, d0);
        r0 = mk(21); r0.mem_wmask = 8'h0F; r0.mem_addr = 64'h1000; r0.mem_wdata = 64'h1122_3344_5566_7788;
        d0 = r0; d0.mem_wdata = r0.mem_wdata ^ 64'h0000_FF00_0000_0000;
        cyc(1, r0, 1, d0);
        r0 = mk(22); r0.mem_addr = 64'h2000; d0 = r0; d0.mem_addr = 64'h3000;
        cyc(1, r0, 1, d0);
        idle_cyc(3);
        chk("qual_count", 64'(match_count), 64'd14);
        chk("qual_mis",   64'(mismatch),    64'd0);

        // rd1_wdata mismatch on order 3, later pairs stay buffered.
        for (int i = 0; i < 6; i++) begin
            r0 = mk(i); d0 = r0;
            if (i == 3) begin
                r0.rd1_addr = 5'd5; d0 = r0; d0.rd1_wdata = r0.rd1_wdata ^ 64'h1;
            end
            cyc(1, r0, 1, d0);
        end
        idle_cyc(4);
        chk("mis_flag",   64'(mismatch),        64'd1);
        chk("mis_fields", 64'(mismatch_fields), 64'h040);
        chk("mis_order",  mismatch_order,       64'd3);
        chk("mis_count",  64'(match_count),     64'd17);
        chk("mis_idle",   64'(idle),            64'd0);
        do_clear();
        chk("clr_mis",   64'(mismatch),    64'd0);
        chk("clr_idle",  64'(idle),        64'd1);
        chk("clr_count", 64'(match_count), 64'd17);

        // Overflow: 9 ref pushes, no DUT.
        for (int i = 0; i < 9; i++) cyc(1, mk(30 + i), 0, '0);
        chk("ovf_before", 64'(overflow), 64'd0);
        idle_cyc(1);
        chk("ovf_after",  64'(overflow), 64'd1);
        do_clear();
        chk("ovf_clr",       64'(overflow),    64'd0);
        chk("ovf_clr_idle",  64'(idle),        64'd1);
        chk("ovf_clr_count", 64'(match_count), 64'd17);

        // Push into a full FIFO with a simultaneous pop.
        for (int i = 40; i < 48; i++) cyc(1, mk(i), 0, '0);
        cyc(0, '0, 1, mk(40));
        cyc(1, mk(48), 1, mk(41));
        for (int i = 42; i < 49; i++) cyc(0, '0, 1, mk(i));
        idle_cyc(3);
        chk("fullpop_ovf",   64'(overflow),    64'd0);
        chk("fullpop_count", 64'(match_count), 64'd26);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) cyc(1, mk(50 + i), 0, '0);
        @(negedge clk);
        ref_valid = 0; dut_valid = 0; rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("mrst_count", 64'(match_count), 64'd0);
        chk("mrst_ovf",   64'(overflow),    64'd0);
        chk("mrst_idle",  64'(idle),        64'd1);
        cyc(1, mk(60), 1, mk(60));
        idle_cyc(3);
        chk("mrst_next", 64'(match_count), 64'd1);

        idle_cyc(2);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
